// File: rtl/bus_pkg.sv
// bus_pkg: shared state type, default parameters and constants for sram_bus_bridge
package bus_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, SRAM, IO, DONE} bus_state_t;
  localparam int          WAIT_CYCLES_DEF = 2;
  localparam logic [15:0] IO_BASE_DEF     = 16'hFF00;
  localparam int          IO_TIMEOUT_DEF  = 63;
  localparam logic [15:0] BUS_ERR_DATA    = 16'hFFFF;
endpackage

// File: rtl/bus_timer.sv
// bus_timer: 8-bit loadable down-counter that stops at zero
//   clk_i/rst_ni : clock, synchronous active-low reset
//   load_i/load_val_i : load the counter (wins over dec_i)
//   dec_i : decrement by one unless already zero
//   cnt_o/zero_o : current count, count == 0
module bus_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       dec_i,
  output logic [7:0] cnt_o,
  output logic       zero_o
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == 8'd0);
endmodule

// File: rtl/sram_bus_bridge.sv
// sram_bus_bridge: runs CPU multiplexed-bus accesses against a wait-stated SRAM or a handshaked I/O port
//   clk_i/n_reset_i : clock, synchronous active-low reset
//   cpu_*/ale_i/n_me_i/n_oe_i/rnw_i/n_wait_o : core side (address/data mux, strobes, stall)
//   sram_*/n_sram_*_o : SRAM address, data and active-low strobes
//   io_*/bus_err_o : I/O port address, data, level request/ack, timeout pulse
module sram_bus_bridge import bus_pkg::*; #(
  parameter int          AW          = 15,
  parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter logic [15:0] IO_BASE     = IO_BASE_DEF,
  parameter int          IO_TIMEOUT  = IO_TIMEOUT_DEF
) (
  input  logic          clk_i,
  input  logic          n_reset_i,
  input  logic [15:0]   cpu_data_out_i,
  output logic [15:0]   cpu_data_in_o,
  input  logic          ale_i,
  input  logic          n_me_i,
  input  logic          n_oe_i,
  input  logic          rnw_i,
  output logic          n_wait_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [15:0]   sram_wdata_o,
  input  logic [15:0]   sram_rdata_i,
  output logic          n_sram_ce_o,
  output logic          n_sram_oe_o,
  output logic          n_sram_we_o,
  output logic [7:0]    io_addr_o,
  output logic [15:0]   io_wdata_o,
  input  logic [15:0]   io_rdata_i,
  output logic          io_req_o,
  output logic          io_wr_o,
  input  logic          io_ack_i,
  output logic          bus_err_o
);
  bus_state_t  state_q, state_d;
  logic [15:0] addr_q, addr_d, data_q, data_d, wdata_q, wdata_d;
  logic        rnw_q, rnw_d, n_wait_q, n_wait_d, ce_q, ce_d, oe_q, oe_d, we_q, we_d;
  logic        io_req_q, io_req_d, io_wr_q, io_wr_d, bus_err_q, bus_err_d;
  logic        t_load, t_dec, t_zero;
  logic [7:0]  t_val, t_cnt;
  bus_timer u_timer (
    .clk_i(clk_i), .rst_ni(n_reset_i), .load_i(t_load), .load_val_i(t_val),
    .dec_i(t_dec), .cnt_o(t_cnt), .zero_o(t_zero)
  );
  // Read data is captured only when the access was a read and the core enables its input
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wdata_d   = wdata_q;
    rnw_d     = rnw_q;
    n_wait_d  = n_wait_q;
    ce_d      = ce_q;
    oe_d      = oe_q;
    we_d      = we_q;
    io_req_d  = io_req_q;
    io_wr_d   = io_wr_q;
    bus_err_d = 1'b0;
    t_load    = 1'b0;
    t_dec     = 1'b0;
    t_val     = '0;
    case (state_q)
      IDLE, DONE: begin
        if (ale_i) begin
          state_d = ADDR;
          addr_d  = cpu_data_out_i;
        end else if (state_q == DONE && n_me_i) state_d = IDLE;
      end
      ADDR: if (!n_me_i) begin
        rnw_d   = rnw_i;
        wdata_d = cpu_data_out_i;
        t_load  = 1'b1;
        if (addr_q < IO_BASE) begin
          state_d  = SRAM;
          t_val    = 8'(WAIT_CYCLES);
          ce_d     = 1'b0;
          oe_d     = !rnw_i;
          we_d     = rnw_i;
          n_wait_d = (WAIT_CYCLES == 0);
        end else begin
          state_d  = IO;
          t_val    = 8'(IO_TIMEOUT);
          io_req_d = 1'b1;
          io_wr_d  = !rnw_i;
          n_wait_d = 1'b0;
        end
      end
      SRAM, IO: begin
        if (n_me_i) state_d = IDLE;
        else if (state_q == IO && io_ack_i) begin
          state_d = DONE;
          data_d  = (rnw_q && !n_oe_i) ? io_rdata_i : data_q;
        end else if (t_zero) begin
          state_d   = DONE;
          bus_err_d = (state_q == IO);
          data_d    = (state_q == IO) ? BUS_ERR_DATA : (rnw_q && !n_oe_i) ? sram_rdata_i : data_q;
        end else begin
          t_dec    = 1'b1;
          // the cycle in which the count will read zero completes the access, so no stall then
          n_wait_d = (t_cnt == 8'd1);
        end
        if (state_d != state_q) begin
          ce_d     = 1'b1;
          oe_d     = 1'b1;
          we_d     = 1'b1;
          io_req_d = 1'b0;
          n_wait_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!n_reset_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      wdata_q   <= '0;
      rnw_q     <= 1'b0;
      n_wait_q  <= 1'b1;
      ce_q      <= 1'b1;
      oe_q      <= 1'b1;
      we_q      <= 1'b1;
      io_req_q  <= 1'b0;
      io_wr_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wdata_q   <= wdata_d;
      rnw_q     <= rnw_d;
      n_wait_q  <= n_wait_d;
      ce_q      <= ce_d;
      oe_q      <= oe_d;
      we_q      <= we_d;
      io_req_q  <= io_req_d;
      io_wr_q   <= io_wr_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign cpu_data_in_o = data_q;
  assign n_wait_o      = n_wait_q;
  assign sram_addr_o   = addr_q[AW-1:0];
  assign sram_wdata_o  = wdata_q;
  assign n_sram_ce_o   = ce_q;
  assign n_sram_oe_o   = oe_q;
  assign n_sram_we_o   = we_q;
  assign io_addr_o     = addr_q[7:0];
  assign io_wdata_o    = wdata_q;
  assign io_req_o      = io_req_q;
  assign io_wr_o       = io_wr_q;
  assign bus_err_o     = bus_err_q;
endmodule

// File: tb/tb_sram_bus_bridge.sv
// tb_sram_bus_bridge: two bridges (2 and 0 wait states, I/O timeout 5) driven in lockstep and checked per access
module tb_sram_bus_bridge;
  localparam int T = 5;
  logic clk = 1'b0, n_reset = 1'b0, ale = 1'b0, n_me = 1'b1, n_oe = 1'b1, rnw = 1'b1, io_ack = 1'b0;
  logic [15:0] cdo = '0, srd = '0, ird = '0;
  logic [15:0] cdi [2], wdat [2], iowd [2];
  logic [14:0] saddr [2];
  logic [7:0]  ioa [2];
  logic nwait [2], nce [2], noe [2], nwe [2], ioreq [2], iowr [2], berr [2];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_bus_bridge #(.WAIT_CYCLES(g == 0 ? 2 : 0), .IO_TIMEOUT(T)) u_dut (
      .clk_i(clk), .n_reset_i(n_reset), .cpu_data_out_i(cdo), .cpu_data_in_o(cdi[g]),
      .ale_i(ale), .n_me_i(n_me), .n_oe_i(n_oe), .rnw_i(rnw), .n_wait_o(nwait[g]),
      .sram_addr_o(saddr[g]), .sram_wdata_o(wdat[g]), .sram_rdata_i(srd),
      .n_sram_ce_o(nce[g]), .n_sram_oe_o(noe[g]), .n_sram_we_o(nwe[g]),
      .io_addr_o(ioa[g]), .io_wdata_o(iowd[g]), .io_rdata_i(ird),
      .io_req_o(ioreq[g]), .io_wr_o(iowr[g]), .io_ack_i(io_ack), .bus_err_o(berr[g])
    );
  end
  typedef struct {
    logic [15:0] addr;
    logic        rnw;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          ack;
    logic        keep;
    logic [15:0] xdata;
    int          xnwait;
    logic        xerr;
  } vec_t;
  typedef struct {
    logic [15:0] data;
    int nwait, ce, oe, we, ioreq, err;
  } exp_t;
  int n_cmp = 0, n_fail = 0;
  logic [15:0] prev [2];
  vec_t tbl [7];
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  function automatic logic [127:0] pk(input int i);
    return {50'b0, cdi[i], nwait[i], nce[i], noe[i], nwe[i], ioreq[i], iowr[i], berr[i], ioa[i], saddr[i], wdat[i], iowd[i]};
  endfunction
  localparam logic [127:0] RST_PK = {50'b0, 16'h0, 7'b1111000, 8'h0, 15'h0, 16'h0, 16'h0};
  // Transaction-level expectation: cycle counts per strobe and the final data word
  function automatic exp_t model(input vec_t v, input int w, input logic [15:0] pd);
    exp_t e;
    int n;
    e = '{data: pd, nwait: 0, ce: 0, oe: 0, we: 0, ioreq: 0, err: 0};
    if (v.addr < 16'hFF00) begin
      e.ce = w + 1;
      e.oe = v.rnw ? w + 1 : 0;
      e.we = v.rnw ? 0 : w + 1;
      e.nwait = w;
      if (v.rnw) e.data = v.rdata;
    end else begin
      n = (v.ack == 0) ? T + 1 : v.ack;
      e.ioreq = n;
      e.nwait = (n > T) ? T : n;
      e.err = (v.ack == 0) ? 1 : 0;
      if (v.ack == 0) e.data = 16'hFFFF;
      else if (v.rnw) e.data = v.rdata;
    end
    return e;
  endfunction
  task automatic run(input vec_t v, input bit use_x, input string tag);
    int nw [2], ce [2], oe [2], we [2], rq [2], er [2], wbad [2];
    exp_t e;
    logic [15:0] xd;
    int xn, xe;
    for (int i = 0; i < 2; i++) begin
      nw[i] = 0; ce[i] = 0; oe[i] = 0; we[i] = 0; rq[i] = 0; er[i] = 0; wbad[i] = 0;
    end
    ale = 1'b1;
    cdo = v.addr;
    step();
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s u%0d addr", tag, i), {saddr[i], ioa[i]}, {v.addr[14:0], v.addr[7:0]});
    ale = 1'b0;
    n_me = 1'b0;
    rnw = v.rnw;
    n_oe = !v.rnw;
    cdo = v.wdata;
    srd = v.rdata;
    ird = v.rdata;
    for (int c = 0; c < 12; c++) begin
      step();
      cdo = 16'($urandom);
      for (int i = 0; i < 2; i++) begin
        nw[i] += int'(!nwait[i]);
        ce[i] += int'(!nce[i]);
        oe[i] += int'(!noe[i]);
        we[i] += int'(!nwe[i]);
        rq[i] += int'(ioreq[i]);
        er[i] += int'(berr[i]);
        wbad[i] += int'(!nwe[i] && wdat[i] !== v.wdata);
      end
      io_ack = (v.ack != 0 && ioreq[0] && rq[0] == v.ack);
    end
    io_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = model(v, i == 0 ? 2 : 0, prev[i]);
      xd = (use_x && i == 0) ? v.xdata : e.data;
      xn = (use_x && i == 0) ? v.xnwait : e.nwait;
      xe = (use_x && i == 0) ? int'(v.xerr) : e.err;
      chk($sformatf("%s u%0d data", tag, i), cdi[i], xd);
      chk($sformatf("%s u%0d nwait_cycles", tag, i), nw[i], xn);
      chk($sformatf("%s u%0d buserr_cycles", tag, i), er[i], xe);
      chk($sformatf("%s u%0d ce/oe/we/req_cycles", tag, i), {ce[i], oe[i], we[i], rq[i]}, {e.ce, e.oe, e.we, e.ioreq});
      chk($sformatf("%s u%0d wdata", tag, i), {wdat[i], iowd[i], wbad[i]}, {v.wdata, v.wdata, 32'd0});
      chk($sformatf("%s u%0d idle_outputs", tag, i), {nwait[i], nce[i], noe[i], nwe[i], ioreq[i]}, 5'b11110);
      if (v.addr >= 16'hFF00) chk($sformatf("%s u%0d iowr", tag, i), iowr[i], !v.rnw);
      prev[i] = e.data;
    end
    if (!v.keep) begin
      n_me = 1'b1;
      step();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    vec_t v;
    tbl[0] = '{16'h0123, 1'b1, 16'h0000, 16'hBEEF, 0, 1'b0, 16'hBEEF, 2, 1'b0};
    tbl[1] = '{16'h0040, 1'b0, 16'h5A5A, 16'h1111, 0, 1'b0, 16'hBEEF, 2, 1'b0};
    tbl[2] = '{16'hFF10, 1'b1, 16'h0000, 16'h00C3, 4, 1'b0, 16'h00C3, 4, 1'b0};
    tbl[3] = '{16'hFF33, 1'b1, 16'h0000, 16'h2222, 0, 1'b1, 16'hFFFF, 5, 1'b1};
    tbl[4] = '{16'h0200, 1'b1, 16'h0000, 16'h1234, 0, 1'b0, 16'h1234, 2, 1'b0};
    tbl[5] = '{16'hFFF0, 1'b0, 16'hA5A5, 16'h3333, 2, 1'b0, 16'h1234, 2, 1'b0};
    tbl[6] = '{16'hFF01, 1'b1, 16'h0000, 16'h7777, 6, 1'b0, 16'h7777, 5, 1'b0};
    prev[0] = '0;
    prev[1] = '0;
    step();
    step();
    for (int i = 0; i < 2; i++) chk($sformatf("reset u%0d", i), pk(i), RST_PK);
    n_reset = 1'b1;
    step();
    for (int k = 0; k < 7; k++) run(tbl[k], 1'b1, $sformatf("vec%0d", k));
    for (int k = 0; k < 24; k++) begin
      v.addr = ($urandom_range(0, 1) == 1) ? {8'hFF, 8'($urandom)} : 16'($urandom_range(0, 16'hFEFF));
      v.rnw = 1'($urandom_range(0, 1));
      v.wdata = 16'($urandom);
      v.rdata = 16'($urandom);
      v.ack = $urandom_range(0, T + 1);
      v.keep = 1'($urandom_range(0, 1));
      v.xdata = '0;
      v.xnwait = 0;
      v.xerr = 1'b0;
      run(v, 1'b0, $sformatf("rnd%0d", k));
    end
    n_me = 1'b1;
    step();
    ale = 1'b1;
    cdo = 16'h0123;
    step();
    ale = 1'b0;
    n_me = 1'b0;
    rnw = 1'b1;
    n_oe = 1'b0;
    srd = 16'hCAFE;
    step();
    step();
    n_me = 1'b1;
    step();
    chk("abort u0 outputs", {nce[0], noe[0], nwe[0], nwait[0], berr[0], ioreq[0]}, 6'b111100);
    chk("abort u0 data", cdi[0], prev[0]);
    chk("abort u1 completed", cdi[1], 16'hCAFE);
    prev[1] = 16'hCAFE;
    n_me = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("nme_no_ale c%0d", c), {nce[0], nce[1], ioreq[0], ioreq[1], nwait[0]}, 5'b11001);
    end
    n_me = 1'b1;
    step();
    ale = 1'b1;
    cdo = 16'hFF20;
    step();
    ale = 1'b0;
    n_me = 1'b0;
    step();
    step();
    chk("midio req", {ioreq[0], ioreq[1], nwait[0]}, 3'b110);
    n_reset = 1'b0;
    step();
    for (int i = 0; i < 2; i++) chk($sformatf("midio reset u%0d", i), pk(i), RST_PK);
    n_reset = 1'b1;
    n_me = 1'b1;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
